// File: rtl/dp_types_pkg.sv
// dp_types_pkg: shared datapath types for the fetch/branch-prediction slice.
//   word_t              32-bit machine word
//   bpred_state_t       2-bit saturating predictor state (BPRED_*)
//   branch_pred_frame_t one BTB entry {state, target}, 34 bits
//   pred_record_t       one in-flight prediction kept until execute resolves it
//   BPU_DEPTH           default number of in-flight prediction records
package dp_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BPRED_NH = 2'b00,   // not taken, hard
        BPRED_NS = 2'b01,   // not taken, soft
        BPRED_TS = 2'b10,   // taken, soft
        BPRED_TH = 2'b11    // taken, hard
    } bpred_state_t;

    typedef struct packed {
        bpred_state_t state;
        word_t        target;
    } branch_pred_frame_t;

    typedef struct packed {
        word_t              pc;
        branch_pred_frame_t entry;
        logic               pred_taken;
        word_t              pred_npc;
    } pred_record_t;

    localparam int BPU_DEPTH = 4;

    function automatic logic bpred_is_taken(input bpred_state_t s);
        return (s == BPRED_TS) || (s == BPRED_TH);
    endfunction

endpackage

// File: rtl/bpu_pred_fifo.sv
// bpu_pred_fifo: in-order circular queue of pred_record_t.
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset (pointers/count)
//   push_i, wdata_i  enqueue a record at the tail
//   pop_i            dequeue the head record
//   flush_i          empty the queue; wins over a same-cycle push
//   rdata_o          head record (combinational read)
//   count_o, full_o, empty_o  occupancy status
module bpu_pred_fifo
    import dp_types_pkg::*;
#(
    parameter int  DEPTH = BPU_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  pred_record_t       wdata_i,
    output pred_record_t       rdata_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    pred_record_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    assign do_pop  = pop_i && !empty_o;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_pop)  head_d = head_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Record storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: client and writer of the 256-entry branch target buffer.
// Fetch side: indexes the BTB with fetch_pc, forms pred_npc/pred_taken and
// records each prediction in an in-order in-flight queue (bpu_pred_fifo).
// Resolve side: pops the oldest record on resolve_valid, raises mispredict with
// correct_pc, and drives the BTB update port (btb_wen/wsel_ind/wdat/phit).
// Ports:
//   CLK, nRST                         clock, asynchronous active-low reset
//   fetch_valid/pc/stall              fetch request
//   pred_npc, pred_taken, queue_full  prediction and back-pressure
//   resolve_valid/is_branch/taken/target  execute outcome for the oldest record
//   mispredict, correct_pc            flush/redirect request
//   underflow_err                     sticky: resolve with nothing in flight
//   btb_rsel_ind, btb_rdat            BTB read port
//   btb_wen, btb_wsel_ind, btb_wdat, btb_phit  BTB update port
// Build option: define BPU_STATS_EN to add stat_branches and stat_mispredicts
// (saturating 32-bit event counters).
module branch_predict_unit
    import dp_types_pkg::*;
#(
    parameter int DEPTH = BPU_DEPTH,
    parameter int IDX_W = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_pc,
    input  logic               fetch_stall,
    output logic [31:0]        pred_npc,
    output logic               pred_taken,
    output logic               queue_full,
    input  logic               resolve_valid,
    input  logic               resolve_is_branch,
    input  logic               resolve_taken,
    input  logic [31:0]        resolve_target,
    output logic               mispredict,
    output logic [31:0]        correct_pc,
    output logic               underflow_err,
    output logic [IDX_W-1:0]   btb_rsel_ind,
    input  branch_pred_frame_t btb_rdat,
    output logic               btb_wen,
    output logic [IDX_W-1:0]   btb_wsel_ind,
    output branch_pred_frame_t btb_wdat,
    output logic               btb_phit
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pred_record_t     push_rec, head_rec;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             resolve_ok;
    word_t            actual_npc;
    logic             underflow_q;
    logic             unused_ok;

    // ---------------- Predict ----------------
    assign btb_rsel_ind = fetch_pc[IDX_W+1:2];
    assign pred_taken   = bpred_is_taken(btb_rdat.state);
    assign pred_npc     = pred_taken ? btb_rdat.target : fetch_pc + 32'd4;

    assign push_rec = '{pc: fetch_pc, entry: btb_rdat,
                        pred_taken: pred_taken, pred_npc: pred_npc};

    bpu_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .push_i  (fetch_valid && !fetch_stall),
        .pop_i   (resolve_valid),
        .flush_i (mispredict),
        .wdata_i (push_rec),
        .rdata_o (head_rec),
        .count_o (fifo_count),
        .full_o  (queue_full),
        .empty_o (fifo_empty)
    );

    // ---------------- Resolve ----------------
    assign resolve_ok = resolve_valid && !fifo_empty;
    assign actual_npc = (resolve_is_branch && resolve_taken) ? resolve_target
                                                             : head_rec.pc + 32'd4;
    // Comparing full next-PCs also catches a non-branch that aliased onto a
    // taken BTB entry.
    assign mispredict = resolve_ok && (actual_npc != head_rec.pred_npc);
    assign correct_pc = actual_npc;

    assign btb_wen          = resolve_ok && resolve_is_branch;
    assign btb_wsel_ind     = head_rec.pc[IDX_W+1:2];
    // Old state is written back; the BTB applies the saturating step from phit.
    assign btb_wdat.state   = head_rec.entry.state;
    assign btb_wdat.target  = resolve_taken ? resolve_target : head_rec.entry.target;
    assign btb_phit         = resolve_taken;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            underflow_q <= 1'b0;
        end else if (resolve_valid && fifo_empty) begin
            underflow_q <= 1'b1;
        end
    end
    assign underflow_err = underflow_q;

    // Recorded prediction flag and occupancy are kept for debug visibility only.
    assign unused_ok = ^{head_rec.pred_taken, fifo_count};

`ifdef BPU_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (btb_wen && (stat_br_q != 32'hFFFF_FFFF))
                stat_br_q <= stat_br_q + 32'd1;
            if (mispredict && (stat_mis_q != 32'hFFFF_FFFF))
                stat_mis_q <= stat_mis_q + 32'd1;
        end
    end
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule
